afh_map_builder: RTL and testbench
==================================

# afh_map_builder

Sequential builder for the AFH remap table used by the hop kernel's adaptive-mapping path. On each start request it scans the 79-channel AFH channel map in basic-hop order and writes the ordered list of used RF channels to an external table RAM, one entry per used channel. At the end of the scan it publishes the used-channel count N, which drives the hop kernel's `regi_AFH_modN`. It runs at link-manager time, whenever the channel map changes, and is never in the per-slot hop path.

## Interface
Parameters:
- `MIN_USED`, default 20: minimum legal used-channel count; any smaller count is a map error.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rstz` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle build request.
- `channel_map` in 80: bit c = 1 means RF channel c is used (c = 0..78); bit 79 is ignored.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `wr_en` out 1: table write strobe, registered.
- `wr_addr` out 7: table index k' = 0..78.
- `wr_data` out 7: RF channel number written at index k'.
- `done` out 1: one-cycle pulse marking the end of the build.
- `modN` out 7: used-channel count N from the last completed build.
- `modN_valid` out 1: `modN` is legal (N >= `MIN_USED`).
- `map_err` out 1: last completed build had N < `MIN_USED`.

## Operation
- States: IDLE, SCAN, FINISH.
- IDLE:
  - `start` = 1 latches `channel_map[78:0]` into an internal copy.
  - Clears the scan index `idx` and the used count `cnt`.
  - Clears `modN_valid` and `map_err`, then moves to SCAN.
- SCAN: one index per cycle, `idx` = 0..78.
  - Basic mapping: ch = 2·idx when idx <= 39; ch = 2·(idx−40)+1 when idx >= 40.
  - If copy[ch] = 1, register a write with `wr_addr`=cnt, `wr_data`=ch, then increment `cnt`.
  - At idx = 78, move to FINISH.
- FINISH: register the results, pulse `done`, return to IDLE.
  - `modN` = cnt in every case, including the error case, for debug.
  - If cnt >= `MIN_USED`: `modN_valid` = 1, `map_err` = 0.
  - Otherwise: `modN_valid` = 0, `map_err` = 1.
- Resulting table order: used even channels ascending, then used odd channels ascending.
- Write addresses are contiguous from 0, with no gaps.
- Widths:
  - `idx` and `cnt` are 7-bit; `cnt` never exceeds 79.
  - ch is computed in 7 bits; its maximum value is 78.
- Changes to `channel_map` after the start cycle are ignored until the next `start`.
- Restart: `start` in SCAN or FINISH aborts the current build and restarts it from idx 0.
  - The new map is latched.
  - `cnt` is cleared.
  - No `done` pulse is issued for the aborted build.
  - Writes already issued stay in the RAM and will be overwritten.
- `start` in the same cycle as the `done` pulse: the FSM is already in IDLE, so `start` is accepted normally.

## Timing
- Reset value of all outputs is 0; the FSM resets to IDLE and `cnt`/`idx` reset to 0.
- Reset mid-scan: everything returns to reset values immediately, and no `done` pulse is issued.
- With `start` sampled at edge S:
  - SCAN occupies cycles S+1 .. S+79, with `idx` = cycle − (S+1).
  - The write for index idx is visible on `wr_*` in cycle S+2+idx.
  - FINISH occupies cycle S+80; the last possible write is visible in that cycle.
  - `done`, `modN`, `modN_valid` and `map_err` update at cycle S+81.
  - `busy` = 1 in cycles S+1 .. S+80 and 0 from S+81.
- Fixed latency of 81 cycles from `start` to `done`, independent of the map contents.
- At most one write per cycle.
- `wr_addr`/`wr_data` hold their last value when `wr_en` = 0.

## Test plan
- Full map (bits 0..78 = 1), `start` at S:
  - 79 writes at cycles S+2..S+80.
  - Entry k' = 2k' for k' <= 39, and 2(k'−40)+1 otherwise.
  - `done` at S+81, `modN` = 79, `modN_valid` = 1.
- Channels 0..19 used:
  - 20 writes with data 0,2,…,18,1,3,…,19 at addresses 0..19.
  - `modN` = 20, `modN_valid` = 1, `map_err` = 0.
- Channels 0..18 used plus bit 79 set:
  - 19 writes.
  - `modN` = 19, `map_err` = 1, `modN_valid` = 0.
  - Bit 79 produces no write.
- Full map, `start` at S, second `start` with channels 60..78 used at S+30:
  - No `done` at S+81.
  - Restarted scan issues 19 writes and `done` at S+30+81 with `modN` = 19 and `map_err` = 1.
- `channel_map` toggled to all-zero at S+10 during a full-map build: result still 79 writes and `modN` = 79.
- `rstz` asserted at S+40 for 1 cycle:
  - All outputs 0 immediately; no `done` follows.
  - A subsequent `start` completes normally in 81 cycles.

Source files
------------

// File: rtl/afh_map_builder.sv
// AFH remap table builder: scans the 79-channel map in basic-hop order and writes
// the used channels contiguously to an external table, then publishes the count N.
module afh_map_builder #(
   parameter int unsigned MIN_USED = 20
) (
   input  logic        clk,
   input  logic        rstz,
   input  logic        start,
   input  logic [79:0] channel_map,
   output logic        busy,
   output logic        wr_en,
   output logic [6:0]  wr_addr,
   output logic [6:0]  wr_data,
   output logic        done,
   output logic [6:0]  modN,
   output logic        modN_valid,
   output logic        map_err
);

   localparam logic [6:0] MinUsed = 7'(MIN_USED);
   localparam logic [6:0] LastIdx = 7'd78;

   typedef enum logic [1:0] {StIdle, StScan, StFinish} state_e;

   state_e      state;
   // Bit 79 is captured but never addressed: ch tops out at 78.
   logic [79:0] map_q;
   logic [6:0]  idx;
   logic [6:0]  cnt;
   logic [6:0]  ch;

   // Basic mapping: first half of idx walks even channels, second half odd ones.
   always_comb begin
      ch = 7'd0;
      if (idx <= 7'd39) ch = idx << 1;
      else              ch = ((idx - 7'd40) << 1) | 7'd1;
   end

   always_ff @(posedge clk or posedge rstz) begin
      if (rstz) begin
         state      <= StIdle;
         map_q      <= '0;
         idx        <= '0;
         cnt        <= '0;
         busy       <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         done       <= 1'b0;
         modN       <= '0;
         modN_valid <= 1'b0;
         map_err    <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         // start wins in every state, so an in-flight build is silently abandoned.
         if (start) begin
            map_q      <= channel_map;
            idx        <= '0;
            cnt        <= '0;
            modN_valid <= 1'b0;
            map_err    <= 1'b0;
            busy       <= 1'b1;
            state      <= StScan;
         end else begin
            unique case (state)
               StIdle: ;
               StScan: begin
                  if (map_q[ch]) begin
                     wr_en   <= 1'b1;
                     wr_addr <= cnt;
                     wr_data <= ch;
                     cnt     <= cnt + 7'd1;
                  end
                  if (idx == LastIdx) state <= StFinish;
                  else                idx   <= idx + 7'd1;
               end
               StFinish: begin
                  modN       <= cnt;
                  modN_valid <= (cnt >= MinUsed);
                  map_err    <= (cnt < MinUsed);
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  state      <= StIdle;
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_afh_map_builder.sv
// Scoreboard bench for afh_map_builder: a reference model queues expected table
// writes and build results; a monitor pops and compares them as the DUT presents them.
module tb_afh_map_builder;

   logic        clk = 1'b0;
   logic        rstz = 1'b1;
   logic        start = 1'b0;
   logic [79:0] channel_map = '0;
   logic        busy, wr_en, done, modN_valid, map_err;
   logic [6:0]  wr_addr, wr_data, modN;

   afh_map_builder #(.MIN_USED(20)) dut (
      .clk         (clk),
      .rstz        (rstz),
      .start       (start),
      .channel_map (channel_map),
      .busy        (busy),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .done        (done),
      .modN        (modN),
      .modN_valid  (modN_valid),
      .map_err     (map_err)
   );

   always #5 clk = ~clk;

   typedef struct {int addr; int data; int cyc;} wr_t;
   typedef struct {int n; bit valid; bit err; int cyc;} res_t;

   wr_t  wq[$];
   res_t rq[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   busy_from = -1;
   int   busy_to = -1;
   int   last_addr = 0;
   int   last_data = 0;

   always @(posedge clk) cyc++;

   // Monitor: sample 2 time units after each rising edge.
   always @(posedge clk) begin
      #2;
      if (!rstz) begin
         checks++;
         if (busy !== ((cyc >= busy_from) && (cyc <= busy_to))) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy,
                     (cyc >= busy_from) && (cyc <= busy_to));
         end
         if (wr_en) begin
            checks++;
            if (wq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write cyc=%0d got addr=%0d data=%0d want none",
                        cyc, wr_addr, wr_data);
            end else begin
               wr_t e;
               e = wq.pop_front();
               if (wr_addr !== 7'(e.addr) || wr_data !== 7'(e.data) || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL write got addr=%0d data=%0d cyc=%0d want addr=%0d data=%0d cyc=%0d",
                           wr_addr, wr_data, cyc, e.addr, e.data, e.cyc);
               end
            end
            last_addr = int'(wr_addr);
            last_data = int'(wr_data);
         end else begin
            checks++;
            if (wr_addr !== 7'(last_addr) || wr_data !== 7'(last_data)) begin
               errors++;
               $display("FAIL wr_hold cyc=%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                        cyc, wr_addr, wr_data, last_addr, last_data);
            end
         end
         if (done) begin
            checks++;
            if (rq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done cyc=%0d got modN=%0d want no done", cyc, modN);
            end else begin
               res_t r;
               r = rq.pop_front();
               if (modN !== 7'(r.n) || modN_valid !== r.valid || map_err !== r.err ||
                   cyc != r.cyc) begin
                  errors++;
                  $display("FAIL result got n=%0d v=%b e=%b cyc=%0d want n=%0d v=%b e=%b cyc=%0d",
                           modN, modN_valid, map_err, cyc, r.n, r.valid, r.err, r.cyc);
               end
            end
         end
      end
   end

   // Reference: table = used even channels ascending, then used odd ones ascending.
   // Channel ch is visited at scan step ch/2 (even) or 40+ch/2 (odd).
   task automatic model_build(input logic [79:0] m, input int c);
      int n = 0;
      for (int ch = 0; ch <= 78; ch += 2)
         if (m[ch]) begin wq.push_back('{n, ch, c + 2 + ch / 2}); n++; end
      for (int ch = 1; ch <= 77; ch += 2)
         if (m[ch]) begin wq.push_back('{n, ch, c + 2 + 40 + ch / 2}); n++; end
      rq.push_back('{n, n >= 20, n < 20, c + 81});
   endtask

   task automatic do_start(input logic [79:0] m);
      @(negedge clk);
      start = 1'b1;
      channel_map = m;
      wq.delete();
      rq.delete();
      model_build(m, cyc);
      busy_from = cyc + 1;
      busy_to = cyc + 80;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      while ((rq.size() != 0) && (t < 200)) begin @(negedge clk); t++; end
      checks++;
      if (rq.size() != 0 || wq.size() != 0) begin
         errors++;
         $display("FAIL build_timeout got pending results=%0d writes=%0d want 0 0",
                  rq.size(), wq.size());
         rq.delete();
         wq.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_zero(input string name);
      checks++;
      if ({busy, wr_en, wr_addr, wr_data, done, modN, modN_valid, map_err} !== '0) begin
         errors++;
         $display("FAIL %s got busy=%b we=%b a=%0d d=%0d done=%b n=%0d v=%b e=%b want all 0",
                  name, busy, wr_en, wr_addr, wr_data, done, modN, modN_valid, map_err);
      end
   endtask

   initial begin
      logic [79:0] full, m;
      logic [95:0] r1, r2;
      full = {1'b0, {79{1'b1}}};

      #1 check_zero("reset_state");
      repeat (2) @(negedge clk);
      rstz = 1'b0;
      repeat (2) @(negedge clk);
      check_zero("post_reset_idle");

      do_start(full);
      wait_done();
      do_start(80'h0_0000_0000_0000_000F_FFFF);
      wait_done();
      do_start({1'b1, 79'h0_0000_0000_0007_FFFF});
      wait_done();

      // Restart at S+30 with channels 60..78: aborted build must not report.
      do_start(full);
      repeat (28) @(negedge clk);
      m = '0;
      for (int c = 60; c <= 78; c++) m[c] = 1'b1;
      do_start(m);
      wait_done();

      // Map changes after the start cycle must be ignored.
      do_start(full);
      repeat (9) @(negedge clk);
      channel_map = '0;
      wait_done();

      // Reset at S+40 mid-scan.
      do_start(full);
      repeat (38) @(negedge clk);
      rstz = 1'b1;
      wq.delete();
      rq.delete();
      busy_to = -1;
      last_addr = 0;
      last_data = 0;
      #1 check_zero("reset_mid_scan");
      @(negedge clk);
      rstz = 1'b0;
      repeat (60) @(negedge clk);
      do_start(full);
      wait_done();

      // Start in the same cycle as done.
      do_start(full);
      repeat (79) @(negedge clk);
      do_start(80'h0_0000_0000_0000_000F_FFFF);
      wait_done();

      for (int i = 0; i < 8; i++) begin
         r1 = {$urandom(), $urandom(), $urandom()};
         r2 = {$urandom(), $urandom(), $urandom()};
         m = r1[79:0];
         if (i % 2 == 1) m = m & r2[79:0];
         if (i == 5) m = m & r1[95:16];
         do_start(m);
         if (i == 3) begin
            repeat ($urandom_range(5, 70)) @(negedge clk);
            channel_map = r2[79:0];
         end
         wait_done();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
